// File: rtl/vip_pkg.sv
// Shared constants for the VIP colour-space stages: pipeline latency,
// Q8 YCbCr->RGB coefficient sets and a saturating 8-bit clamp.
package vip_pkg;

   localparam int VIP_LATENCY_YCC2RGB = 3;
   localparam int VIP_ROUND_Q8        = 128;

   // Full range (JPEG), luma taken as Y*256
   localparam int VIP_FR_K_RCR = 359;
   localparam int VIP_FR_K_GCB = 88;
   localparam int VIP_FR_K_GCR = 183;
   localparam int VIP_FR_K_BCB = 454;

   // Studio range (BT.601), luma taken as 298*(Y-16)
   localparam int VIP_SR_K_Y   = 298;
   localparam int VIP_SR_K_RCR = 409;
   localparam int VIP_SR_K_GCB = 100;
   localparam int VIP_SR_K_GCR = 208;
   localparam int VIP_SR_K_BCB = 516;

   function automatic logic [7:0] vip_clamp8(input logic signed [19:0] v);
      if (v[19])
         return 8'd0;
      else if (v > 20'sd255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// Fixed-depth shift register for the {vsync, href, clken} framing bundle,
// synchronous active-low reset; shared by the VIP pipeline stages.
module vip_sync_delay #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   input  logic href,
   input  logic clken,
   output logic vsync_dly,
   output logic href_dly,
   output logic clken_dly
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [2:0] q_reg;
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (!rst_n)
                  q_reg <= '0;
               else
                  q_reg <= {vsync, href, clken};
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (!rst_n)
                  q_reg <= '0;
               else
                  q_reg <= g_stage[gi-1].q_reg;
            end
         end
      end
   endgenerate

   assign {vsync_dly, href_dly, clken_dly} = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/vip_ycbcr444_rgb888.sv
// 3-stage YCbCr 4:4:4 -> RGB888 converter with framing carried alongside.
// Define VIP_FULL_RANGE_EN for full-range (JPEG) maths; otherwise BT.601 studio range.
module vip_ycbcr444_rgb888
   import vip_pkg::*;
#(
   parameter int OUT_BLANK_ZERO = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_Y,
   input  logic [7:0] per_img_Cb,
   input  logic [7:0] per_img_Cr,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] post_img_red,
   output logic [7:0] post_img_green,
   output logic [7:0] post_img_blue
);

`ifdef VIP_FULL_RANGE_EN
   localparam logic signed [10:0] K_RCR = 11'(VIP_FR_K_RCR);
   localparam logic signed [10:0] K_GCB = 11'(VIP_FR_K_GCB);
   localparam logic signed [10:0] K_GCR = 11'(VIP_FR_K_GCR);
   localparam logic signed [10:0] K_BCB = 11'(VIP_FR_K_BCB);
`else
   localparam logic signed [10:0] K_Y   = 11'(VIP_SR_K_Y);
   localparam logic signed [10:0] K_RCR = 11'(VIP_SR_K_RCR);
   localparam logic signed [10:0] K_GCB = 11'(VIP_SR_K_GCB);
   localparam logic signed [10:0] K_GCR = 11'(VIP_SR_K_GCR);
   localparam logic signed [10:0] K_BCB = 11'(VIP_SR_K_BCB);
`endif
   localparam logic signed [19:0] ROUND = 20'(VIP_ROUND_Q8);

   logic signed [8:0]  cb_off, cr_off;
   logic signed [19:0] y_term;
   logic signed [19:0] y_s1_reg;
   logic signed [17:0] rcr_s1_reg, gcb_s1_reg, gcr_s1_reg, bcb_s1_reg;
   logic signed [19:0] r_sum, g_sum, b_sum;
   logic signed [19:0] r_s2_reg, g_s2_reg, b_s2_reg;
   logic [7:0]         red_reg, green_reg, blue_reg;

   assign cb_off = $signed({1'b0, per_img_Cb}) - 9'sd128;
   assign cr_off = $signed({1'b0, per_img_Cr}) - 9'sd128;

`ifdef VIP_FULL_RANGE_EN
   assign y_term = $signed({4'b0, per_img_Y, 8'b0});
`else
   logic signed [8:0] y_off;
   // Y below 16 gives a negative luma term; the final clamp absorbs it
   assign y_off  = $signed({1'b0, per_img_Y}) - 9'sd16;
   assign y_term = 20'(y_off) * 20'(K_Y);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_s1_reg   <= '0;
         rcr_s1_reg <= '0;
         gcb_s1_reg <= '0;
         gcr_s1_reg <= '0;
         bcb_s1_reg <= '0;
      end else begin
         y_s1_reg   <= y_term;
         rcr_s1_reg <= 18'(cr_off) * 18'(K_RCR);
         gcb_s1_reg <= 18'(cb_off) * 18'(K_GCB);
         gcr_s1_reg <= 18'(cr_off) * 18'(K_GCR);
         bcb_s1_reg <= 18'(cb_off) * 18'(K_BCB);
      end
   end

   always_comb begin
      r_sum = y_s1_reg + 20'(rcr_s1_reg) + ROUND;
      g_sum = y_s1_reg - 20'(gcb_s1_reg) - 20'(gcr_s1_reg) + ROUND;
      b_sum = y_s1_reg + 20'(bcb_s1_reg) + ROUND;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_reg <= '0;
         g_s2_reg <= '0;
         b_s2_reg <= '0;
      end else begin
         r_s2_reg <= r_sum >>> 8;
         g_s2_reg <= g_sum >>> 8;
         b_s2_reg <= b_sum >>> 8;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         red_reg   <= '0;
         green_reg <= '0;
         blue_reg  <= '0;
      end else begin
         red_reg   <= vip_clamp8(r_s2_reg);
         green_reg <= vip_clamp8(g_s2_reg);
         blue_reg  <= vip_clamp8(b_s2_reg);
      end
   end

   vip_sync_delay #(
      .DEPTH (VIP_LATENCY_YCC2RGB)
   ) u_sync_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .vsync     (per_frame_vsync),
      .href      (per_frame_href),
      .clken     (per_frame_clken),
      .vsync_dly (post_frame_vsync),
      .href_dly  (post_frame_href),
      .clken_dly (post_frame_clken)
   );

   // Blanking keys off the delayed href so it lines up with the stage-3 data
   assign post_img_red   = (OUT_BLANK_ZERO != 0 && !post_frame_href) ? 8'd0 : red_reg;
   assign post_img_green = (OUT_BLANK_ZERO != 0 && !post_frame_href) ? 8'd0 : green_reg;
   assign post_img_blue  = (OUT_BLANK_ZERO != 0 && !post_frame_href) ? 8'd0 : blue_reg;

endmodule
